kbd_event_queue: RTL and testbench
==================================

// Module: kbd_event_queue
// PURPOSE
//  Sits directly downstream of the keyboard matrix scanner (kbd_col drive / kbd_row sample / debounce).
//  Consumes one debounced row vector per scanned column and diffs it against a stored key-state matrix.
//  Each changed key becomes a press/release event in a FWFT FIFO that the CPU CSR interface drains.
//  Single clock; the scanner's lpclk-domain outputs are already synchronised upstream.
// PARAMETERS
//  ROWS        9    matrix rows, i.e. bits per column vector (<=16)
//  COLS        10   matrix columns (<=16)
//  FIFO_DEPTH  16   event FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1             system clock
//  rst           in   1             synchronous, active-high reset
//  col_valid     in   1             column vector offered by scanner
//  col_ready     out  1             block can accept a column vector
//  col_idx       in   4             column index of offered vector
//  col_rows      in   ROWS          debounced row states for that column, 1 = pressed
//  evt_rd        in   1             pop head event (one-cycle strobe)
//  evt_data      out  9             head event {press, col[3:0], row[3:0]}; valid when !evt_empty
//  evt_empty     out  1             FIFO empty
//  evt_count     out  log2(D)+1     FIFO occupancy, 0..FIFO_DEPTH
//  overflow      out  1             sticky: an event was dropped
//  overflow_clr  in   1             clears overflow
//  irq           out  1             level interrupt = !evt_empty
// BEHAVIOUR
//  Reset: key matrix all 0 (released); FIFO empty; evt_count=0; evt_empty=1; irq=0; overflow=0;
//   evt_data=0; col_ready=0 while rst high, 1 on first cycle after; FSM -> IDLE. Reset mid-DIFF aborts
//   the walk: no further events pushed, matrix cleared.
//  FSM IDLE: col_ready=1. On col_valid&col_ready, latch col_idx/col_rows, row ptr=0, -> DIFF.
//   col_idx>=COLS: accepted, discarded, stays IDLE, no events, matrix untouched.
//  FSM DIFF: col_ready=0; one row per cycle, ptr 0..ROWS-1 ascending. If latched bit != stored bit:
//   push {latched bit, col, ptr}, update stored bit. After ptr=ROWS-1 -> IDLE.
//   col_ready therefore low exactly ROWS cycles after each valid accept; next accept earliest
//   ROWS+1 cycles after previous. Unchanged vectors produce no events, same timing.
//  Push latency: event visible on evt_data / counted in evt_count the cycle after its DIFF cycle.
//  FIFO: first-word-fall-through. evt_rd when empty ignored (no underflow, count stays 0).
//   Push when full and no evt_rd: event dropped, overflow<=1, stored key bit STILL updated
//   (no re-emit on the next scan). Push with evt_rd in the same cycle when full: both succeed,
//   count unchanged. Pointers wrap mod FIFO_DEPTH.
//  overflow: set wins over overflow_clr in the same cycle.
//  Arithmetic: col/row fields zero-extended to 4 bits; evt_count never exceeds FIFO_DEPTH.
// TESTING
//  1 reset, then col 2 rows=9'b000001000 -> single event 9'h123, evt_count=1, irq=1; rd -> empty, irq=0.
//  2 same vector again -> no event; then col 2 rows=0 -> event 9'h023 (release).
//  3 col 4 rows=9'b000101000 -> events 9'h143 then 9'h145 in order; col_ready low exactly 9 cycles.
//  4 17 presses (distinct keys) no reads -> count=16, overflow=1, 17th lost; re-scan same
//    vectors -> no new events; overflow_clr -> 0; read+push when full keeps count=16.
//  5 col_idx=12 with rows=9'h1FF -> no events, matrix unchanged (verify via later scan of col 0..9).
//  6 assert rst during DIFF of a 2-change vector -> at most first event kept before reset,
//    after reset FIFO empty, matrix 0, col_ready=1 next cycle after rst drops.

Source files
------------

// File: rtl/kbd_event_queue.sv
// Keyboard event queue: diffs each scanned column vector against the stored
// key-state matrix and queues one press/release event per changed key in a
// first-word-fall-through FIFO for the CPU to drain.
module kbd_event_queue #(
   parameter int ROWS       = 9,
   parameter int COLS       = 10,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          col_valid,
   output logic                          col_ready,
   input  logic [3:0]                    col_idx,
   input  logic [ROWS-1:0]               col_rows,
   input  logic                          evt_rd,
   output logic [8:0]                    evt_data,
   output logic                          evt_empty,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   input  logic                          overflow_clr,
   output logic                          irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [3:0]    LAST_ROW = 4'(ROWS - 1);

   typedef enum logic {
      IDLE,
      DIFF
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [3:0]        lat_col;
   logic [ROWS-1:0]   lat_rows;
   logic [3:0]        ptr;
   logic [ROWS-1:0]   keys [COLS];

   logic [8:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              col_ok;
   logic              accept;
   logic              cur_bit;
   logic              stored_bit;
   logic              push;
   logic [8:0]        evt_word;
   logic              pop;
   logic              wr_en;
   logic              drop;

   assign col_ok     = ({1'b0, col_idx} < 5'(COLS));
   assign accept     = col_valid && col_ready;
   assign cur_bit    = lat_rows[ptr];
   assign stored_bit = keys[lat_col][ptr];
   assign push       = (state == DIFF) && (cur_bit != stored_bit);
   assign evt_word   = {cur_bit, lat_col, ptr};
   assign pop        = evt_rd && (count != '0);
   assign wr_en      = push && ((count != FULL_CNT) || pop);
   assign drop       = push && (count == FULL_CNT) && !pop;

   assign evt_count  = count;
   assign evt_empty  = (count == '0);
   assign irq        = (count != '0);
   assign evt_data   = (count == '0) ? 9'd0 : mem[rd_ptr];

   // Next-state and handshake: ready only while idle and out of reset; an
   // out-of-range column is accepted but never starts a diff walk.
   always_comb begin
      state_next = state;
      col_ready  = 1'b0;
      case (state)
         IDLE: begin
            col_ready = !rst;
            if (col_valid && !rst && col_ok) begin
               state_next = DIFF;
            end
         end
         DIFF: begin
            if (ptr == LAST_ROW) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus the latched column; the row pointer walks one row per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lat_col  <= '0;
         lat_rows <= '0;
         ptr      <= '0;
      end else begin
         state <= state_next;
         if (accept && col_ok) begin
            lat_col  <= col_idx;
            lat_rows <= col_rows;
            ptr      <= '0;
         end else if (state == DIFF) begin
            ptr <= ptr + 4'd1;
         end
      end
   end

   // Stored key matrix: a changed bit is always recorded, even if its event is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < COLS; c++) begin
            keys[c] <= '0;
         end
      end else if (push) begin
         keys[lat_col][ptr] <= cur_bit;
      end
   end

   // FIFO storage; contents need no reset because evt_data is masked when empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= evt_word;
      end
   end

   // FIFO pointers and occupancy; a pop frees room for a same-cycle push when full.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag; a new drop takes priority over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Testbench for kbd_event_queue: a queue-based event model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_kbd_event_queue;

   localparam int ROWS  = 9;
   localparam int COLS  = 10;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              col_valid = 1'b0;
   logic              col_ready;
   logic [3:0]        col_idx = '0;
   logic [ROWS-1:0]   col_rows = '0;
   logic              evt_rd = 1'b0;
   logic [8:0]        evt_data;
   logic              evt_empty;
   logic [4:0]        evt_count;
   logic              overflow;
   logic              overflow_clr = 1'b0;
   logic              irq;

   int checks = 0;
   int errors = 0;

   kbd_event_queue #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .col_valid(col_valid), .col_ready(col_ready),
      .col_idx(col_idx), .col_rows(col_rows), .evt_rd(evt_rd),
      .evt_data(evt_data), .evt_empty(evt_empty), .evt_count(evt_count),
      .overflow(overflow), .overflow_clr(overflow_clr), .irq(irq)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      int         due;
      logic [8:0] data;
   } pend_t;

   logic [ROWS-1:0] mkeys [COLS];
   logic [8:0]      mq [$];
   pend_t           pend [$];
   logic            movf = 1'b0;
   int              cyc = 0;
   int              busy_until = 0;
   bit              started = 1'b0;

   // Model update at each rising edge: the walk of an accepted column emits the
   // event for row r on edge accept+1+r and keeps the scanner blocked ROWS cycles.
   always @(posedge clk) begin
      bit   pop_m, full_m, drop_m;
      pend_t p;
      cyc++;
      started = 1'b1;
      if (rst) begin
         mq.delete();
         pend.delete();
         for (int c = 0; c < COLS; c++) mkeys[c] = '0;
         movf = 1'b0;
         busy_until = cyc;
      end else begin
         pop_m  = evt_rd && (mq.size() > 0);
         full_m = (mq.size() == DEPTH);
         drop_m = 1'b0;
         if (pop_m) void'(mq.pop_front());
         if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (!full_m || pop_m) mq.push_back(p.data);
            else drop_m = 1'b1;
         end
         if (drop_m) movf = 1'b1;
         else if (overflow_clr) movf = 1'b0;
         if (col_valid && (cyc - 1 >= busy_until)) begin
            if (int'(col_idx) < COLS) begin
               for (int r = 0; r < ROWS; r++) begin
                  if (col_rows[r] != mkeys[col_idx][r]) begin
                     p.due  = cyc + 1 + r;
                     p.data = {col_rows[r], col_idx, r[3:0]};
                     pend.push_back(p);
                     mkeys[col_idx][r] = col_rows[r];
                  end
               end
               busy_until = cyc + ROWS;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (started) begin
         checkOutput("col_ready", 32'(col_ready), 32'(!rst && (cyc >= busy_until)));
         checkOutput("evt_count", 32'(evt_count), 32'(mq.size()));
         checkOutput("evt_empty", 32'(evt_empty), 32'(mq.size() == 0));
         checkOutput("irq", 32'(irq), 32'(mq.size() != 0));
         checkOutput("overflow", 32'(overflow), 32'(movf));
         if (mq.size() > 0) checkOutput("evt_data", 32'(evt_data), 32'(mq[0]));
      end
   end

   // ---------------- stimulus ----------------
   // Drive one cycle of inputs shortly after the falling edge, then let comb settle.
   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] idx,
                                input logic [ROWS-1:0] rows, input logic rd, input logic clr);
      @(negedge clk);
      #1;
      rst = r; col_valid = v; col_idx = idx; col_rows = rows; evt_rd = rd; overflow_clr = clr;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
   endtask

   task automatic readOne();
      applyStimulus(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b0);
   endtask

   // Offer a column until accepted; returns right after the accepting cycle.
   task automatic scanColumn(input logic [3:0] idx, input logic [ROWS-1:0] rows);
      int n = 0;
      applyStimulus(1'b0, 1'b1, idx, rows, 1'b0, 1'b0);
      while (!col_ready && n < 50) begin
         applyStimulus(1'b0, 1'b1, idx, rows, 1'b0, 1'b0);
         n++;
      end
      if (n >= 50) checkOutput("scan_accept_timeout", 32'(col_ready), 32'd1);
   endtask

   logic [ROWS-1:0] known [COLS];

   initial begin
      int lows;
      // 1: reset and a single press
      applyStimulus(1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0);
      checkOutput("rst_col_ready", 32'(col_ready), 32'd0);
      checkOutput("rst_count", 32'(evt_count), 32'd0);
      checkOutput("rst_empty", 32'(evt_empty), 32'd1);
      checkOutput("rst_irq", 32'(irq), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_data", 32'(evt_data), 32'd0);
      idle(1);
      checkOutput("ready_after_rst", 32'(col_ready), 32'd1);
      scanColumn(4'd2, 9'b000001000);
      idle(ROWS + 1);
      checkOutput("t1_count", 32'(evt_count), 32'd1);
      checkOutput("t1_data", 32'(evt_data), 32'h123);
      checkOutput("t1_irq", 32'(irq), 32'd1);
      readOne();
      idle(1);
      checkOutput("t1_empty", 32'(evt_empty), 32'd1);
      checkOutput("t1_irq_low", 32'(irq), 32'd0);
      readOne();
      idle(1);
      checkOutput("t1_underflow", 32'(evt_count), 32'd0);

      // 2: unchanged vector, then release
      scanColumn(4'd2, 9'b000001000);
      idle(ROWS + 1);
      checkOutput("t2_nochange", 32'(evt_count), 32'd0);
      scanColumn(4'd2, 9'b000000000);
      idle(ROWS + 1);
      checkOutput("t2_release", 32'(evt_data), 32'h023);
      readOne();

      // 3: two changes in ascending row order, ready low ROWS cycles
      scanColumn(4'd4, 9'b000101000);
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         idle(1);
         if (!col_ready) lows++;
         else break;
      end
      checkOutput("t3_ready_low", 32'(lows), 32'd9);
      checkOutput("t3_first", 32'(evt_data), 32'h143);
      readOne();
      idle(1);
      checkOutput("t3_second", 32'(evt_data), 32'h145);
      readOne();

      // 4: overflow with 17 distinct presses
      scanColumn(4'd0, 9'h1FF);
      scanColumn(4'd1, 9'h0FF);
      idle(ROWS + 1);
      checkOutput("t4_full", 32'(evt_count), 32'd16);
      checkOutput("t4_ovf", 32'(overflow), 32'd1);
      checkOutput("t4_head", 32'(evt_data), 32'h100);
      scanColumn(4'd0, 9'h1FF);
      scanColumn(4'd1, 9'h0FF);
      idle(ROWS + 1);
      checkOutput("t4_no_reemit", 32'(evt_count), 32'd16);
      applyStimulus(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
      idle(1);
      checkOutput("t4_ovf_clr", 32'(overflow), 32'd0);
      scanColumn(4'd3, 9'h001);
      readOne();
      idle(ROWS + 1);
      checkOutput("t4_rdpush_count", 32'(evt_count), 32'd16);
      checkOutput("t4_rdpush_ovf", 32'(overflow), 32'd0);
      checkOutput("t4_rdpush_head", 32'(evt_data), 32'h101);
      repeat (16) readOne();
      idle(1);
      checkOutput("t4_drained", 32'(evt_empty), 32'd1);

      // 5: out-of-range column is ignored
      scanColumn(4'd12, 9'h1FF);
      idle(1);
      checkOutput("t5_stay_idle", 32'(col_ready), 32'd1);
      for (int c = 0; c < COLS; c++) known[c] = '0;
      known[0] = 9'h1FF; known[1] = 9'h0FF; known[3] = 9'h001; known[4] = 9'h028;
      for (int c = 0; c < COLS; c++) scanColumn(4'(c), known[c]);
      idle(ROWS + 1);
      checkOutput("t5_matrix_same", 32'(evt_count), 32'd0);

      // 6: reset during a two-change walk
      scanColumn(4'd5, 9'h003);
      idle(1);
      applyStimulus(1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0);
      checkOutput("t6_first_kept", 32'(evt_data), 32'h150);
      checkOutput("t6_ready_in_rst", 32'(col_ready), 32'd0);
      idle(1);
      checkOutput("t6_empty", 32'(evt_empty), 32'd1);
      checkOutput("t6_ready", 32'(col_ready), 32'd1);
      scanColumn(4'd0, 9'h000);
      idle(ROWS + 1);
      checkOutput("t6_matrix_clear", 32'(evt_count), 32'd0);
      scanColumn(4'd5, 9'h003);
      idle(ROWS + 1);
      checkOutput("t6_rescan", 32'(evt_count), 32'd2);
      readOne();
      readOne();

      // Random phase: two read-rate regimes, occasional reset and clear
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 2) == 0,
                          4'($urandom_range(0, 11)),
                          ROWS'($urandom),
                          (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 15) == 0);
         end
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
